seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a bank of common-enable 7-segment digits.

---
 rtl/seg7_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan of packed-BCD digits.
// Loads are buffered once and committed at frame boundaries.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_digits,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_digit,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int MAXL = (REFRESH_DIV > GUARD_CYCLES) ?
                        REFRESH_DIV : GUARD_CYCLES;
  localparam int CW = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST =
    CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {S_GUARD, S_SHOW} state_t;

  // With no guard period the scan starts straight in SHOW.
  localparam state_t S_START = (GUARD_CYCLES > 0) ? S_GUARD : S_SHOW;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nxt;
  logic [IW-1:0]           r_idx;
  logic [IW-1:0]           w_idx_nxt;
  logic                    w_frame_end;

  logic [4*NUM_DIGITS-1:0] r_active;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic                    r_pfull;
  logic                    r_ready;
  logic                    w_accept;
  logic                    w_pfull_nxt;

  logic [3:0]              w_nib;
  logic                    w_blank;
  logic                    w_zero_run;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [NUM_DIGITS-1:0]   w_onehot;

  // State, slot counter and digit index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_START;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state: guard period, lit period, index advance at slot end.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_frame_end = 1'b0;
    unique case (r_state)
      S_GUARD: begin
        if (r_cnt == GUARD_LAST) begin
          w_state_nxt = S_SHOW;
          w_cnt_nxt   = '0;
        end
      end
      S_SHOW: begin
        if (r_cnt == SHOW_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (GUARD_CYCLES > 0) ? S_GUARD : S_SHOW;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt   = '0;
            w_frame_end = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end
      end
      default: w_state_nxt = S_START;
    endcase
  end

  // Handshake: one-deep buffer, emptied at a frame boundary.
  always_comb begin
    w_accept    = load_valid && r_ready;
    w_pfull_nxt = r_pfull;
    if (w_frame_end) w_pfull_nxt = 1'b0;
    if (w_accept)    w_pfull_nxt = 1'b1;
  end

  // Pending/active display registers and registered ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active <= '0;
      r_pend   <= '0;
      r_pfull  <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      if (w_frame_end && r_pfull) r_active <= r_pend;
      if (w_accept) r_pend <= load_digits;
      r_pfull <= w_pfull_nxt;
      r_ready <= !w_pfull_nxt;
    end
  end

  // Current nibble and leading-zero blanking for the scanned digit.
  always_comb begin
    w_nib      = 4'd0;
    w_blank    = 1'b0;
    w_zero_run = 1'b1;
    w_lz       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (r_active[4*i +: 4] == 4'd0);
      w_lz[i]    = w_zero_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib   = r_active[4*i +: 4];
        w_blank = blank_lz && (i != 0) && w_lz[i];
      end
    end
    w_onehot = NUM_DIGITS'(1) << r_idx;
  end

  // Registered display outputs, one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_sel  <= '0;
      bcd_digit  <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_frame_end;
      if (r_state == S_SHOW) begin
        digit_sel <= w_blank ? '0 : w_onehot;
        bcd_digit <= (w_nib > 4'd9) ? 4'hF : w_nib;
      end else begin
        digit_sel <= '0;
      end
    end
  end

  assign load_ready = r_ready;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with a cycle-position
// reference model (slot = 5 cycles, frame = 20 cycles).
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int GC = 1;
  localparam int SLOT = GC + RD;
  localparam int FRAME = ND * SLOT;

  logic          clk;
  logic          rst_n;
  logic          load_valid;
  logic          load_ready;
  logic [15:0]   load_digits;
  logic          blank_lz;
  logic [3:0]    bcd_digit;
  logic [ND-1:0] digit_sel;
  logic          frame_done;

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD_CYCLES(GC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_digits(load_digits),
    .blank_lz   (blank_lz),
    .bcd_digit  (bcd_digit),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [ND-1:0] sel;
    logic [3:0]    bcd;
    logic          chk_bcd;
    logic          fd;
    logic          rdy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int          m_n;
  logic [15:0] m_active;
  logic [15:0] m_pend;
  logic        m_pfull;

  task automatic model_step();
    exp_t e;
    int p;
    int slot;
    logic [15:0] sh;
    logic [3:0] nib;
    logic acc;
    logic bnd;
    if (!rst_n) begin
      m_n = 0;
      m_active = '0;
      m_pend = '0;
      m_pfull = 1'b0;
      e.sel = '0;
      e.bcd = 4'd0;
      e.chk_bcd = 1'b1;
      e.fd = 1'b0;
      e.rdy = 1'b1;
    end else begin
      m_n++;
      p = (m_n - 1) % FRAME;
      slot = p / SLOT;
      sh = m_active >> (4 * slot);
      nib = sh[3:0];
      e.sel = '0;
      e.bcd = 4'd0;
      e.chk_bcd = 1'b0;
      if ((p % SLOT) >= GC) begin
        if (!(blank_lz && slot != 0 && sh == 16'd0)) begin
          e.sel = ND'(1 << slot);
          e.bcd = (nib > 4'd9) ? 4'hF : nib;
          e.chk_bcd = 1'b1;
        end
      end
      bnd = (p == FRAME - 1);
      e.fd = bnd;
      acc = load_valid && !m_pfull;
      if (bnd && m_pfull) begin
        m_active = m_pend;
        m_pfull = 1'b0;
      end
      if (acc) begin
        m_pend = load_digits;
        m_pfull = 1'b1;
      end
      e.rdy = !m_pfull;
    end
    q.push_back(e);
  endtask

  initial begin
    m_n = 0;
    m_active = '0;
    m_pend = '0;
    m_pfull = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compares registered outputs away from the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (digit_sel !== e.sel) begin
          errors++;
          $display("FAIL digit_sel t=%0t got %b exp %b",
                   $time, digit_sel, e.sel);
        end
        checks++;
        if (frame_done !== e.fd) begin
          errors++;
          $display("FAIL frame_done t=%0t got %b exp %b",
                   $time, frame_done, e.fd);
        end
        checks++;
        if (load_ready !== e.rdy) begin
          errors++;
          $display("FAIL load_ready t=%0t got %b exp %b",
                   $time, load_ready, e.rdy);
        end
        if (e.chk_bcd) begin
          checks++;
          if (bcd_digit !== e.bcd) begin
            errors++;
            $display("FAIL bcd_digit t=%0t got %h exp %h",
                     $time, bcd_digit, e.bcd);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load1(input logic [15:0] d);
    load_valid  = 1'b1;
    load_digits = d;
    cyc(1);
    load_valid  = 1'b0;
  endtask

  function automatic logic [15:0] rnd_digits();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 7) == 0)
        d[4*i +: 4] = 4'($urandom_range(10, 15));
      else if ($urandom_range(0, 2) == 0)
        d[4*i +: 4] = 4'd0;
      else
        d[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return d;
  endfunction

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0;
    load_digits = 16'h0;
    blank_lz = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(47);
    load1(16'h1234);
    cyc(45);
    load1(16'h0050);
    blank_lz = 1'b1;
    cyc(50);
    blank_lz = 1'b0;
    load_valid = 1'b1;
    load_digits = 16'h9876;
    cyc(3);
    load_digits = 16'h4321;
    cyc(50);
    load_valid = 1'b0;
    load1(16'h3C21);
    cyc(45);
    cyc(7);
    load1(16'h5555);
    cyc(2);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(45);
    for (int k = 0; k < 2000; k++) begin
      load_valid = ($urandom_range(0, 5) == 0);
      load_digits = rnd_digits();
      if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
      rst_n = ($urandom_range(0, 399) != 0);
      cyc(1);
    end
    rst_n = 1'b1;
    load_valid = 1'b0;
    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
